hdmi_audio_acr_gen: RTL and testbench

//  Multi-rate HDMI audio clock-regeneration and PCM framing stage. Sits between the

---
 rtl/hdmi_audio_pkg.sv | 41 ++++
 rtl/hdmi_audio_gain_ramp.sv | 54 +++++
 rtl/hdmi_audio_acr_gen.sv | 195 +++++++++++++++++++
 tb/tb_hdmi_audio_acr_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_audio_pkg.sv
// Shared HDMI audio definitions: rate and FSM encodings, ACR counter width,
// and the per-rate N/CTS/ACR-period lookup used by the board tops.
package hdmi_audio_pkg;

   localparam int ACR_CNT_W = 6;

   localparam logic [1:0] RATE_48K  = 2'd0;
   localparam logic [1:0] RATE_44K1 = 2'd1;
   localparam logic [1:0] RATE_32K  = 2'd2;
   localparam logic [1:0] RATE_RSVD = 2'd3;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_MUTE   = 2'd1;
   localparam logic [1:0] ST_SWITCH = 2'd2;
   localparam logic [1:0] ST_SETTLE = 2'd3;

   typedef struct packed {
      logic [19:0]          n;
      logic [19:0]          cts;
      logic [ACR_CNT_W-1:0] p_m1;
   } rate_cfg_t;

   function automatic logic [1:0] decode_rate(input logic [1:0] rs);
      return (rs == RATE_RSVD) ? RATE_48K : rs;
   endfunction

   // ACR period is N/128, so the last count is taken straight from N's upper bits
   function automatic rate_cfg_t rate_lookup(input logic [1:0] rate,
                                             input int n_32k, input int n_44k1, input int n_48k,
                                             input int cts_32k, input int cts_44k1, input int cts_48k);
      rate_cfg_t cfg;
      case (rate)
         RATE_44K1: begin cfg.n = 20'(n_44k1); cfg.cts = 20'(cts_44k1); end
         RATE_32K:  begin cfg.n = 20'(n_32k);  cfg.cts = 20'(cts_32k);  end
         default:   begin cfg.n = 20'(n_48k);  cfg.cts = 20'(cts_48k);  end
      endcase
      cfg.p_m1 = cfg.n[ACR_CNT_W+6:7] - ACR_CNT_W'(1);
      return cfg;
   endfunction

endpackage

// File: rtl/hdmi_audio_gain_ramp.sv
// Soft-mute gain register and signed gain multiply for both channels.
// Only built when HDMI_ACR_SOFTMUTE_EN is defined.
`ifdef HDMI_ACR_SOFTMUTE_EN
module hdmi_audio_gain_ramp #(
   parameter int AUDIO_BITS = 16,
   parameter int RAMP_BITS  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clken,
   input  logic                  ramp_up,
   input  logic                  ramp_down,
   input  logic [AUDIO_BITS-1:0] in_l,
   input  logic [AUDIO_BITS-1:0] in_r,
   output logic [RAMP_BITS:0]    gain,
   output logic [AUDIO_BITS-1:0] out_l,
   output logic [AUDIO_BITS-1:0] out_r
);

   localparam int PW = AUDIO_BITS + RAMP_BITS + 1;
   localparam logic [RAMP_BITS:0] GAIN_FULL = {1'b1, {RAMP_BITS{1'b0}}};

   logic [RAMP_BITS:0]   gain_q, gain_d;
   logic signed [PW-1:0] prod_l, prod_r, shr_l, shr_r;
   logic                 unused_shr;

   always_comb begin
      gain_d = gain_q;
      if (clken) begin
         if (ramp_down && gain_q != '0)
            gain_d = gain_q - 1'b1;
         else if (ramp_up && gain_q != GAIN_FULL)
            gain_d = gain_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) gain_q <= GAIN_FULL;
      else     gain_q <= gain_d;
   end

   // gain <= 1.0, so the product always fits and the upper bits are pure sign
   assign prod_l = $signed({{(RAMP_BITS+1){in_l[AUDIO_BITS-1]}}, in_l}) * $signed({{AUDIO_BITS{1'b0}}, gain_q});
   assign prod_r = $signed({{(RAMP_BITS+1){in_r[AUDIO_BITS-1]}}, in_r}) * $signed({{AUDIO_BITS{1'b0}}, gain_q});
   assign shr_l  = prod_l >>> RAMP_BITS;
   assign shr_r  = prod_r >>> RAMP_BITS;
   assign out_l  = shr_l[AUDIO_BITS-1:0];
   assign out_r  = shr_r[AUDIO_BITS-1:0];
   assign gain   = gain_q;

   assign unused_shr = ^{shr_l[PW-1:AUDIO_BITS], shr_r[PW-1:AUDIO_BITS]};

endmodule
`endif

// File: rtl/hdmi_audio_acr_gen.sv
// HDMI audio ACR/N/CTS generator and stereo PCM framing with a mute-switch-settle
// sequence on rate change. Optional soft-mute gain ramp: HDMI_ACR_SOFTMUTE_EN.
module hdmi_audio_acr_gen
   import hdmi_audio_pkg::*;
#(
   parameter int AUDIO_BITS     = 16,
   parameter int N_32K          = 4096,
   parameter int N_44K1         = 6272,
   parameter int N_48K          = 6144,
   parameter int CTS_32K        = 27000,
   parameter int CTS_44K1       = 30000,
   parameter int CTS_48K        = 27000,
   parameter int SETTLE_SAMPLES = 64,
   parameter int RAMP_BITS      = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clken,
   input  logic [1:0]            rate_sel,
   input  logic [AUDIO_BITS-1:0] pcm_l_in,
   input  logic [AUDIO_BITS-1:0] pcm_r_in,
   output logic [AUDIO_BITS-1:0] pcm_l,
   output logic [AUDIO_BITS-1:0] pcm_r,
   output logic                  pcm_valid,
   output logic                  pcm_acr,
   output logic [19:0]           pcm_n,
   output logic [19:0]           pcm_cts,
   output logic                  select_44100,
   output logic                  rate_busy
);

   localparam rate_cfg_t CFG_RESET = rate_lookup(RATE_48K, N_32K, N_44K1, N_48K,
                                                 CTS_32K, CTS_44K1, CTS_48K);

   logic [1:0]            state_q, state_d;
   logic [1:0]            active_q, active_d;
   logic [1:0]            target_q, target_d;
   logic [ACR_CNT_W-1:0]  acr_cnt_q, acr_cnt_d;
   logic [ACR_CNT_W-1:0]  acr_last_q, acr_last_d;
   logic [7:0]            settle_cnt_q, settle_cnt_d;
   logic [AUDIO_BITS-1:0] pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
   logic                  pcm_valid_q, pcm_valid_d;
   logic                  pcm_acr_q, pcm_acr_d;
   logic [19:0]           pcm_n_q, pcm_n_d, pcm_cts_q, pcm_cts_d;
   logic                  sel44_q, sel44_d;

   logic [1:0]            rate_req;
   rate_cfg_t             cfg_target;
   logic [AUDIO_BITS-1:0] gate_l, gate_r;
   logic                  mute_done;

   assign rate_req   = decode_rate(rate_sel);
   assign cfg_target = rate_lookup(target_q, N_32K, N_44K1, N_48K, CTS_32K, CTS_44K1, CTS_48K);

`ifdef HDMI_ACR_SOFTMUTE_EN
   logic [RAMP_BITS:0]    gain;
   logic [AUDIO_BITS-1:0] scaled_l, scaled_r;
   logic                  pass;

   hdmi_audio_gain_ramp #(
      .AUDIO_BITS (AUDIO_BITS),
      .RAMP_BITS  (RAMP_BITS)
   ) u_gain_ramp (
      .clk       (clk),
      .rst       (reset),
      .clken     (clken),
      .ramp_up   (state_q == ST_RUN),
      .ramp_down (state_q == ST_MUTE),
      .in_l      (pcm_l_in),
      .in_r      (pcm_r_in),
      .gain      (gain),
      .out_l     (scaled_l),
      .out_r     (scaled_r)
   );

   assign pass      = (state_q == ST_RUN) || (state_q == ST_MUTE);
   assign gate_l    = pass ? scaled_l : '0;
   assign gate_r    = pass ? scaled_r : '0;
   assign mute_done = (gain == '0);
`else
   localparam int unused_ramp_bits = RAMP_BITS;
   logic [AUDIO_BITS-1:0] pass_mask;

   assign pass_mask = {AUDIO_BITS{state_q == ST_RUN}};
   assign gate_l    = pcm_l_in & pass_mask;
   assign gate_r    = pcm_r_in & pass_mask;
   assign mute_done = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      active_d     = active_q;
      target_d     = target_q;
      acr_cnt_d    = acr_cnt_q;
      acr_last_d   = acr_last_q;
      settle_cnt_d = settle_cnt_q;
      pcm_l_d      = pcm_l_q;
      pcm_r_d      = pcm_r_q;
      pcm_valid_d  = clken;
      pcm_acr_d    = 1'b0;
      pcm_n_d      = pcm_n_q;
      pcm_cts_d    = pcm_cts_q;
      sel44_d      = sel44_q;

      if (clken) begin
         pcm_l_d = gate_l;
         pcm_r_d = gate_r;
      end

      // A strobe in the SWITCH cycle is the first count of the new period
      if (state_q == ST_SWITCH) begin
         acr_cnt_d = clken ? ACR_CNT_W'(1) : '0;
      end else if (clken) begin
         if (acr_cnt_q == acr_last_q) begin
            acr_cnt_d = '0;
            pcm_acr_d = 1'b1;
         end else begin
            acr_cnt_d = acr_cnt_q + 1'b1;
         end
      end

      case (state_q)
         ST_RUN: begin
            if (clken && rate_req != active_q) begin
               target_d = rate_req;
               state_d  = ST_MUTE;
            end
         end
         ST_MUTE: begin
            if (clken && mute_done) state_d = ST_SWITCH;
         end
         ST_SWITCH: begin
            active_d     = target_q;
            pcm_n_d      = cfg_target.n;
            pcm_cts_d    = cfg_target.cts;
            acr_last_d   = cfg_target.p_m1;
            sel44_d      = (target_q == RATE_44K1);
            settle_cnt_d = '0;
            state_d      = ST_SETTLE;
         end
         default: begin
            if (clken) begin
               if (settle_cnt_q == 8'(SETTLE_SAMPLES - 1)) begin
                  target_d = rate_req;
                  state_d  = (rate_req != active_q) ? ST_MUTE : ST_RUN;
               end else begin
                  settle_cnt_d = settle_cnt_q + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_RUN;
         active_q     <= RATE_48K;
         target_q     <= RATE_48K;
         acr_cnt_q    <= '0;
         acr_last_q   <= CFG_RESET.p_m1;
         settle_cnt_q <= '0;
         pcm_l_q      <= '0;
         pcm_r_q      <= '0;
         pcm_valid_q  <= 1'b0;
         pcm_acr_q    <= 1'b0;
         pcm_n_q      <= CFG_RESET.n;
         pcm_cts_q    <= CFG_RESET.cts;
         sel44_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         active_q     <= active_d;
         target_q     <= target_d;
         acr_cnt_q    <= acr_cnt_d;
         acr_last_q   <= acr_last_d;
         settle_cnt_q <= settle_cnt_d;
         pcm_l_q      <= pcm_l_d;
         pcm_r_q      <= pcm_r_d;
         pcm_valid_q  <= pcm_valid_d;
         pcm_acr_q    <= pcm_acr_d;
         pcm_n_q      <= pcm_n_d;
         pcm_cts_q    <= pcm_cts_d;
         sel44_q      <= sel44_d;
      end
   end

   assign pcm_l        = pcm_l_q;
   assign pcm_r        = pcm_r_q;
   assign pcm_valid    = pcm_valid_q;
   assign pcm_acr      = pcm_acr_q;
   assign pcm_n        = pcm_n_q;
   assign pcm_cts      = pcm_cts_q;
   assign select_44100 = sel44_q;
   assign rate_busy    = (state_q != ST_RUN);

endmodule

// File: tb/tb_hdmi_audio_acr_gen.sv
// Self-checking bench for hdmi_audio_acr_gen: a strobe-level reference model of
// ACR timing, rate switching and sample gating, compared every clock.
module tb_hdmi_audio_acr_gen;

   localparam int AB     = 16;
   localparam int RB     = 6;
   localparam int SETTLE = 64;
   localparam int FULL   = 1 << RB;
`ifdef HDMI_ACR_SOFTMUTE_EN
   localparam bit SOFT = 1'b1;
`else
   localparam bit SOFT = 1'b0;
`endif

   localparam int M_RUNNING  = 0;
   localparam int M_MUTING   = 1;
   localparam int M_SETTLING = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          clken = 1'b0;
   logic [1:0]    rate_sel = 2'd0;
   logic [AB-1:0] pcm_l_in = '0, pcm_r_in = '0;
   logic [AB-1:0] pcm_l, pcm_r;
   logic          pcm_valid, pcm_acr, select_44100, rate_busy;
   logic [19:0]   pcm_n, pcm_cts;

   int checks = 0;
   int errors = 0;
   int acr_seen = 0;
   bit const_in = 1'b0;

   // reference model state
   int            m_n, m_tgt, m_mode, m_acr, m_settle_left, m_gain;
   bit            m_switch_next;
   logic [AB-1:0] e_l, e_r;
   bit            e_valid, e_acr;

   always #5 clk = ~clk;

   hdmi_audio_acr_gen #(
      .AUDIO_BITS     (AB),
      .N_32K          (4096),
      .N_44K1         (6272),
      .N_48K          (6144),
      .CTS_32K        (27000),
      .CTS_44K1       (30000),
      .CTS_48K        (27000),
      .SETTLE_SAMPLES (SETTLE),
      .RAMP_BITS      (RB)
   ) dut (
      .clk          (clk),
      .reset        (rst),
      .clken        (clken),
      .rate_sel     (rate_sel),
      .pcm_l_in     (pcm_l_in),
      .pcm_r_in     (pcm_r_in),
      .pcm_l        (pcm_l),
      .pcm_r        (pcm_r),
      .pcm_valid    (pcm_valid),
      .pcm_acr      (pcm_acr),
      .pcm_n        (pcm_n),
      .pcm_cts      (pcm_cts),
      .select_44100 (select_44100),
      .rate_busy    (rate_busy)
   );

   function automatic int n_of(input logic [1:0] rs);
      if (rs == 2'd1) return 6272;
      if (rs == 2'd2) return 4096;
      return 6144;
   endfunction

   function automatic int cts_of(input int n);
      return (n == 6272) ? 30000 : 27000;
   endfunction

   function automatic logic [AB-1:0] scale(input logic [AB-1:0] x, input int g);
      int v;
      v = int'($signed(x)) * g;
      v = v >>> RB;
      return v[AB-1:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_n = 6144; m_tgt = 6144; m_mode = M_RUNNING; m_acr = 0;
      m_settle_left = 0; m_gain = FULL; m_switch_next = 1'b0;
      e_l = '0; e_r = '0; e_valid = 1'b0; e_acr = 1'b0;
   endtask

   // advance the model by one clock edge with the inputs the DUT just sampled
   task automatic model_edge(input bit c, input logic [1:0] rs,
                             input logic [AB-1:0] l, input logic [AB-1:0] r);
      e_valid = c;
      e_acr   = 1'b0;
      if (m_switch_next) begin
         m_switch_next = 1'b0;
         m_n = m_tgt;
         m_mode = M_SETTLING;
         m_settle_left = SETTLE;
         m_acr = c ? 1 : 0;
         if (c) begin e_l = '0; e_r = '0; end
      end else if (c) begin
         m_acr++;
         if (m_acr == m_n / 128) begin e_acr = 1'b1; m_acr = 0; end
         case (m_mode)
            M_RUNNING: begin
               e_l = scale(l, m_gain);
               e_r = scale(r, m_gain);
               if (SOFT && m_gain < FULL) m_gain++;
               if (n_of(rs) != m_n) begin m_mode = M_MUTING; m_tgt = n_of(rs); end
            end
            M_MUTING: begin
               e_l = SOFT ? scale(l, m_gain) : '0;
               e_r = SOFT ? scale(r, m_gain) : '0;
               if (!SOFT || m_gain == 0) m_switch_next = 1'b1;
               else m_gain--;
            end
            default: begin
               e_l = '0; e_r = '0;
               m_settle_left--;
               if (m_settle_left == 0) begin
                  if (n_of(rs) != m_n) begin m_mode = M_MUTING; m_tgt = n_of(rs); end
                  else m_mode = M_RUNNING;
               end
            end
         endcase
      end
   endtask

   task automatic check_all();
      chk("pcm_valid", 32'(pcm_valid), 32'(e_valid));
      chk("pcm_acr", 32'(pcm_acr), 32'(e_acr));
      chk("pcm_l", 32'(pcm_l), 32'(e_l));
      chk("pcm_r", 32'(pcm_r), 32'(e_r));
      chk("pcm_n", 32'(pcm_n), 32'(m_n));
      chk("pcm_cts", 32'(pcm_cts), 32'(cts_of(m_n)));
      chk("select_44100", 32'(select_44100), 32'(m_n == 6272));
      chk("rate_busy", 32'(rate_busy), 32'(m_mode != M_RUNNING || m_switch_next));
   endtask

   task automatic check_reset_values();
      chk("rst_pcm_l", 32'(pcm_l), 32'h0);
      chk("rst_pcm_r", 32'(pcm_r), 32'h0);
      chk("rst_valid", 32'(pcm_valid), 32'h0);
      chk("rst_acr", 32'(pcm_acr), 32'h0);
      chk("rst_n", 32'(pcm_n), 32'd6144);
      chk("rst_cts", 32'(pcm_cts), 32'd27000);
      chk("rst_sel44", 32'(select_44100), 32'h0);
      chk("rst_busy", 32'(rate_busy), 32'h0);
   endtask

   task automatic cycle(input bit c, input logic [1:0] rs);
      clken    = c;
      rate_sel = rs;
      pcm_l_in = const_in ? 16'h7FFF : 16'($urandom);
      pcm_r_in = const_in ? 16'h8001 : 16'($urandom);
      @(posedge clk);
      model_edge(c, rs, pcm_l_in, pcm_r_in);
      #1;
      check_all();
      if (pcm_acr) acr_seen++;
   endtask

   task automatic run_strobes(input int n, input int gap_min, input int gap_max, input logic [1:0] rs);
      for (int i = 0; i < n; i++) begin
         int gap;
         gap = $urandom_range(gap_max, gap_min);
         for (int k = 1; k < gap; k++) cycle(1'b0, rs);
         cycle(1'b1, rs);
      end
   endtask

   initial begin
      int guard;
      model_reset();
      #2 rst = 1'b1;
      #1 check_reset_values();
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;

      // steady 48k: 200 strobes every 4 clocks
      acr_seen = 0;
      run_strobes(200, 4, 4, 2'd0);
      chk("acr_pulses_48k", 32'(acr_seen), 32'd4);

      // switch to 44.1k with irregular strobe spacing
      run_strobes(300, 1, 4, 2'd1);
      chk("n_44k1", 32'(pcm_n), 32'd6272);

      // 32k requested then withdrawn inside SETTLE
      run_strobes(3, 4, 4, 2'd2);
      run_strobes(250, 2, 4, 2'd0);
      chk("n_back_48k", 32'(pcm_n), 32'd6144);

      // reserved code aliases to the active 48k rate
      run_strobes(60, 1, 3, 2'd3);

      // back-to-back strobes so one lands in the switch cycle
      run_strobes(200, 1, 1, 2'd1);
      run_strobes(200, 1, 2, 2'd0);

      // asynchronous reset in the middle of SETTLE
      run_strobes(2, 2, 2, 2'd2);
      guard = 0;
      while (m_mode != M_SETTLING && guard < 500) begin
         run_strobes(1, 2, 2, 2'd2);
         guard++;
      end
      chk("reach_settle", 32'(m_mode == M_SETTLING), 32'd1);
      run_strobes(5, 2, 2, 2'd2);
      rst = 1'b1;
      #1 check_reset_values();
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      run_strobes(120, 1, 4, 2'd0);

      // full-scale constant input through a switch and back
      const_in = 1'b1;
      run_strobes(200, 2, 3, 2'd1);
      run_strobes(250, 2, 3, 2'd0);
      const_in = 1'b0;

      // random tail
      for (int s = 0; s < 12; s++)
         run_strobes($urandom_range(100, 10), 1, 4, 2'($urandom_range(3, 0)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
